// File: rtl/dcache_wb_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : dcache_wb_buffer_if
// Brief    : Dcache write port, hazard probe and AXI write channels of the
//            write-back buffer, bundled for port connection.
// Revision : 1.0
// ============================================================================
interface dcache_wb_buffer_if;
   logic         wr_req;
   logic [2:0]   wr_type;
   logic [31:0]  wr_addr;
   logic [3:0]   wr_wstrb;
   logic [127:0] wr_data;
   logic         wr_rdy;

   logic [31:0]  chk_addr;
   logic         chk_hit;
   logic         empty;

   logic [3:0]   awid;
   logic [31:0]  awaddr;
   logic [7:0]   awlen;
   logic [2:0]   awsize;
   logic [1:0]   awburst;
   logic [1:0]   awlock;
   logic [3:0]   awcache;
   logic [2:0]   awprot;
   logic         awvalid;
   logic         awready;

   logic [3:0]   wid;
   logic [31:0]  wdata;
   logic [3:0]   wstrb;
   logic         wlast;
   logic         wvalid;
   logic         wready;

   logic [3:0]   bid;
   logic [1:0]   bresp;
   logic         bvalid;
   logic         bready;

   // The buffer itself: accepts Dcache writes, masters the AXI write channels.
   modport slave (
      input  wr_req, wr_type, wr_addr, wr_wstrb, wr_data, chk_addr,
             awready, wready, bid, bresp, bvalid,
      output wr_rdy, chk_hit, empty,
             awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
             wid, wdata, wstrb, wlast, wvalid, bready
   );

   modport master (
      output wr_req, wr_type, wr_addr, wr_wstrb, wr_data, chk_addr,
             awready, wready, bid, bresp, bvalid,
      input  wr_rdy, chk_hit, empty,
             awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
             wid, wdata, wstrb, wlast, wvalid, bready
   );
endinterface
`default_nettype wire

// File: rtl/dcache_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : dcache_wb_buffer
// Brief    : FIFO of Dcache line evictions / uncached stores drained one at a
//            time as AXI write bursts, with a line-address hazard probe.
// Revision : 1.0
// ============================================================================
module dcache_wb_buffer #(
   parameter int         DEPTH  = 2,
   parameter logic [3:0] AXI_ID = 4'd1
) (
   input logic               aclk,
   input logic               aresetn,
   dcache_wb_buffer_if.slave bus
);
   localparam int                 c_ptr_w     = $clog2(DEPTH);
   localparam int                 c_cnt_w     = c_ptr_w + 1;
   localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(DEPTH);
   localparam logic [2:0]         c_type_line = 3'b100;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_AW   = 2'd1,
      S_W    = 2'd2,
      S_B    = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_nxt;
   logic [1:0]          r_beat;
   logic [1:0]          w_beat_nxt;
   logic [c_ptr_w-1:0]  r_wr_ptr;
   logic [c_ptr_w-1:0]  r_rd_ptr;
   logic [c_cnt_w-1:0]  r_count;
   logic [DEPTH-1:0]    r_valid;

   logic [2:0]          r_type [DEPTH];
   logic [31:0]         r_addr [DEPTH];
   logic [3:0]          r_strb [DEPTH];
   logic [127:0]        r_data [DEPTH];

   logic                w_full;
   logic                w_push;
   logic                w_pop;
   logic [DEPTH-1:0]    w_set_mask;
   logic [DEPTH-1:0]    w_clr_mask;
   logic [2:0]          w_head_type;
   logic [31:0]         w_head_addr;
   logic [3:0]          w_head_strb;
   logic [127:0]        w_head_data;
   logic                w_head_line;
   logic [7:0]          w_awlen;
   logic                w_wlast;
   logic                w_hit;
   logic                w_awvalid;
   logic                w_wvalid;
   logic                w_bready;
   logic                w_unused;

   assign w_full     = (r_count == c_depth);
   assign w_push     = bus.wr_req && !w_full;
   assign w_pop      = (r_state == S_B) && bus.bvalid;
   assign w_set_mask = w_push ? (DEPTH'(1) << r_wr_ptr) : '0;
   assign w_clr_mask = w_pop  ? (DEPTH'(1) << r_rd_ptr) : '0;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_valid  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
         r_valid <= (r_valid & ~w_clr_mask) | w_set_mask;
      end
   end

   // Payload needs no reset: r_valid alone decides whether a slot means anything.
   always_ff @(posedge aclk) begin
      if (w_push) begin
         r_type[r_wr_ptr] <= bus.wr_type;
         r_addr[r_wr_ptr] <= bus.wr_addr;
         r_strb[r_wr_ptr] <= bus.wr_wstrb;
         r_data[r_wr_ptr] <= bus.wr_data;
      end
   end

   assign w_head_type = r_type[r_rd_ptr];
   assign w_head_addr = r_addr[r_rd_ptr];
   assign w_head_strb = r_strb[r_rd_ptr];
   assign w_head_data = r_data[r_rd_ptr];
   assign w_head_line = (w_head_type == c_type_line);
   assign w_awlen     = w_head_line ? 8'd3 : 8'd0;
   assign w_wlast     = (r_beat == w_awlen[1:0]);

   // The in-flight head stays valid until its B response pops it.
   always_comb begin
      w_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_valid[i] && (r_addr[i][31:4] == bus.chk_addr[31:4])) w_hit = 1'b1;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state <= S_IDLE;
         r_beat  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_beat  <= w_beat_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_beat_nxt  = r_beat;
      w_awvalid   = 1'b0;
      w_wvalid    = 1'b0;
      w_bready    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_valid[r_rd_ptr]) w_state_nxt = S_AW;
         end
         S_AW: begin
            w_awvalid = 1'b1;
            if (bus.awready) begin
               w_state_nxt = S_W;
               w_beat_nxt  = '0;
            end
         end
         S_W: begin
            w_wvalid = 1'b1;
            if (bus.wready) begin
               w_beat_nxt = r_beat + 2'd1;
               if (w_wlast) w_state_nxt = S_B;
            end
         end
         S_B: begin
            w_bready = 1'b1;
            if (bus.bvalid) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign bus.awid    = AXI_ID;
   assign bus.awaddr  = w_head_line ? {w_head_addr[31:4], 4'h0} : w_head_addr;
   assign bus.awlen   = w_awlen;
   assign bus.awsize  = w_head_line ? 3'd2 : {1'b0, w_head_type[1:0]};
   assign bus.awburst = 2'b01;
   assign bus.awlock  = 2'b00;
   assign bus.awcache = 4'h0;
   assign bus.awprot  = 3'h0;
   assign bus.awvalid = w_awvalid;

   assign bus.wid     = AXI_ID;
   assign bus.wdata   = w_head_data[32*r_beat +: 32];
   assign bus.wstrb   = w_head_line ? 4'hf : w_head_strb;
   assign bus.wlast   = w_wlast;
   assign bus.wvalid  = w_wvalid;
   assign bus.bready  = w_bready;

   assign bus.wr_rdy  = !w_full;
   assign bus.empty   = (r_count == '0) && (r_state == S_IDLE);
   assign bus.chk_hit = w_hit;

   // Response ID/status carry no information for a single outstanding write.
   assign w_unused = ^{bus.bid, bus.bresp, bus.chk_addr[3:0]};
endmodule
`default_nettype wire
